// File: rtl/booth_sched.sv
// rtl/booth_sched.sv - two-client round-robin sequencer for a shared 8-bit Booth multiplier.
// Steps the multiplier controller by its observed state code; watchdog aborts hung operations.
module booth_sched #(
  parameter int TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  mcand0,
  input  logic [7:0]  mplier0,
  input  logic [7:0]  mcand1,
  input  logic [7:0]  mplier1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [15:0] product,
  output logic        err,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic        mul_go,
  output logic        mul_rst,
  input  logic [2:0]  mul_state,
  input  logic [15:0] mul_product
);

  typedef enum logic [2:0] {IDLE, LDMD, GO1, LDMP, ARM, RUN, RESP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        cur, cur_nxt, last, last_nxt, pick;
  logic [7:0]  op_a, op_a_nxt, op_b, op_b_nxt;
  logic [7:0]  wd, wd_nxt;
  logic [15:0] product_nxt;
  logic        err_nxt;
  logic [1:0]  gnt_nxt, done_nxt;
  logic [7:0]  mul_a_nxt;
  logic        mul_go_nxt, mul_rst_nxt, busy_nxt;

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    last_nxt    = last;
    op_a_nxt    = op_a;
    op_b_nxt    = op_b;
    wd_nxt      = 8'd0;
    product_nxt = product;
    err_nxt     = err;
    gnt_nxt     = 2'b00;
    done_nxt    = 2'b00;
    // With both requesting, serve the one not served last; otherwise the lone requester.
    pick        = (req == 2'b11) ? ~last : req[1];

    case (state)
      IDLE: begin
        if (|req) begin
          cur_nxt   = pick;
          op_a_nxt  = pick ? mcand1 : mcand0;
          op_b_nxt  = pick ? mplier1 : mplier0;
          gnt_nxt   = pick ? 2'b10 : 2'b01;
          state_nxt = LDMD;
        end
      end
      RESP: begin
        last_nxt  = cur;
        state_nxt = IDLE;
      end
      default: begin
        wd_nxt = wd + 8'd1;
        case (state)
          LDMD: state_nxt = GO1;
          GO1:  if (mul_state == 3'b001) state_nxt = LDMP;
          LDMP: if (mul_state == 3'b010) state_nxt = ARM;
          ARM:  if (mul_state == 3'b011) state_nxt = RUN;
          RUN: begin
            if (mul_state == 3'b110) begin
              product_nxt = mul_product;
              err_nxt     = 1'b0;
              state_nxt   = RESP;
            end
          end
          default: state_nxt = IDLE;
        endcase
        // A genuine completion on the final watchdog cycle still wins over the abort.
        if (wd == WD_LAST && state_nxt != RESP) begin
          product_nxt = 16'd0;
          err_nxt     = 1'b1;
          state_nxt   = RESP;
        end
      end
    endcase

    if (state_nxt == RESP) done_nxt = cur_nxt ? 2'b10 : 2'b01;

    // Outputs are registered, so they are derived from the state being entered.
    mul_rst_nxt = (state_nxt == IDLE) || (state_nxt == RESP);
    mul_go_nxt  = (state_nxt == GO1) || (state_nxt == ARM);
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      LDMD, GO1:      mul_a_nxt = op_a_nxt;
      LDMP, ARM, RUN: mul_a_nxt = op_b_nxt;
      default:        mul_a_nxt = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur     <= 1'b0;
      last    <= 1'b1;
      op_a    <= 8'd0;
      op_b    <= 8'd0;
      wd      <= 8'd0;
      product <= 16'd0;
      err     <= 1'b0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      mul_a   <= 8'd0;
      mul_go  <= 1'b0;
      mul_rst <= 1'b1;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      last    <= last_nxt;
      op_a    <= op_a_nxt;
      op_b    <= op_b_nxt;
      wd      <= wd_nxt;
      product <= product_nxt;
      err     <= err_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      mul_a   <= mul_a_nxt;
      mul_go  <= mul_go_nxt;
      mul_rst <= mul_rst_nxt;
    end
  end

endmodule
